logged_event_arbiter: RTL

//  Multi-channel successor to the single-bit logged synchroniser: captures events on NCH async-sourced

---
 rtl/logged_event_arbiter_if.sv | 30 +++
 rtl/logged_event_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/logged_event_arbiter_if.sv
// Event record channel: one record (channel id, occurrence count, overflow flag) per valid/ready transfer.
// The arbiter drives the record through the master modport; the consumer returns ready through the slave modport.
interface logged_event_arbiter_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
);
   localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

   logic             evt_vld;
   logic             evt_rdy;
   logic [IDW-1:0]   evt_id;
   logic [CNT_W-1:0] evt_cnt;
   logic             evt_ovf;

   modport master (
      output evt_vld,
      output evt_id,
      output evt_cnt,
      output evt_ovf,
      input  evt_rdy
   );

   modport slave (
      input  evt_vld,
      input  evt_id,
      input  evt_cnt,
      input  evt_ovf,
      output evt_rdy
   );
endinterface

// File: rtl/logged_event_arbiter.sv
// Synchronises NCH event inputs into sticky per-channel logs with saturating counts and drains
// them round-robin, one record per transfer, through a valid/ready output register.
module logged_event_arbiter #(
   parameter int NCH         = 4,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NCH-1:0]            ev_in,
   input  logic [NCH-1:0]            ev_dis,
   input  logic                      flush,
   output logic [NCH-1:0]            pend,
   logged_event_arbiter_if.master    evt
);
   localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } out_state_t;

   out_state_t       state_q;
   logic [NCH-1:0]   sync_s;
   logic [NCH-1:0]   prev_q;
   logic [NCH-1:0]   det;
   logic [NCH-1:0]   hit;
   logic [NCH-1:0]   log_q;
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [NCH-1:0]   ovf_q;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   win;
   logic             win_found;
   logic             can_load;
   logic             load_en;

   // The synchroniser chain is cleared by reset only; flush leaves it running.
   generate
      if (SYNC_STAGES == 0) begin : g_no_sync
         assign sync_s = ev_in;
      end else begin : g_sync
         logic [NCH-1:0] chain_q [SYNC_STAGES];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  chain_q[i] <= '0;
               end
            end else begin
               chain_q[0] <= ev_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  chain_q[i] <= chain_q[i-1];
               end
            end
         end

         assign sync_s = chain_q[SYNC_STAGES-1];
      end
   endgenerate

   // prev tracks even while a channel is disabled, so edges seen then are never replayed later.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
      end else begin
         prev_q <= sync_s;
      end
   end

   assign det  = (EDGE_MODE != 0) ? (sync_s & ~prev_q) : sync_s;
   assign hit  = det & ~ev_dis;
   assign pend = log_q;

   // Round-robin winner: first pending log after the last-served channel, wrapping at NCH-1.
   always_comb begin
      int idx;
      win       = '0;
      win_found = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(ptr_q) + k) % NCH;
         if (!win_found && log_q[idx]) begin
            win_found = 1'b1;
            win       = IDW'(idx);
         end
      end
   end

   assign can_load = (state_q == ST_EMPTY) || evt.evt_rdy;
   assign load_en  = !flush && win_found && can_load;

   // A hit landing in the cycle its channel is snapshotted starts the fresh log instead of being lost.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         log_q <= '0;
         ovf_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (load_en && (win == IDW'(i))) begin
               log_q[i] <= hit[i];
               cnt_q[i] <= CNT_W'(hit[i]);
               ovf_q[i] <= 1'b0;
            end else if (hit[i]) begin
               log_q[i] <= 1'b1;
               if (cnt_q[i] != CNT_MAX) begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end else begin
                  ovf_q[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Output register FSM; the record stays frozen while FULL until the consumer accepts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         evt.evt_vld <= 1'b0;
         evt.evt_id  <= '0;
         evt.evt_cnt <= '0;
         evt.evt_ovf <= 1'b0;
         ptr_q       <= IDW'(NCH - 1);
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         evt.evt_vld <= 1'b0;
         evt.evt_id  <= '0;
         evt.evt_cnt <= '0;
         evt.evt_ovf <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (load_en) begin
                  state_q     <= ST_FULL;
                  evt.evt_vld <= 1'b1;
                  evt.evt_id  <= win;
                  evt.evt_cnt <= cnt_q[win];
                  evt.evt_ovf <= ovf_q[win];
                  ptr_q       <= win;
               end
            end
            ST_FULL: begin
               if (evt.evt_rdy) begin
                  if (load_en) begin
                     evt.evt_id  <= win;
                     evt.evt_cnt <= cnt_q[win];
                     evt.evt_ovf <= ovf_q[win];
                     ptr_q       <= win;
                  end else begin
                     state_q     <= ST_EMPTY;
                     evt.evt_vld <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               evt.evt_vld <= 1'b0;
            end
         endcase
      end
   end
endmodule
